// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the in-order pipeline
// writeback and the multiply/divide unit. Muldiv results wait in a small FIFO
// and drain in cycles the pipeline leaves idle. Decode-stage hazards against
// pending results are flagged. A bubble is forced when the FIFO head starves.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   wb_we, wb_dst, wb_data       pipeline writeback request (always wins the port)
//   md_valid, md_dst, md_data    muldiv result offer
//   md_ready                     FIFO can take a muldiv result (count < DEPTH)
//   rs_addr, rt_addr             decode-stage source registers
//   hazard                       a source matches a pending muldiv write
//   wb_stall                     pipeline must present a bubble (registered)
//   rf_we, rf_dst, rf_data       registered register-file write port
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_dst,
    input  logic [31:0] md_data,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        hazard,
    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_dst,
    output logic [31:0] rf_data
);

    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [7:0]  Limit = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StPend, StForce} state_e;

    logic [4:0]       dst_q  [DEPTH];
    logic [4:0]       dst_d  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [7:0]       starve_q, starve_d;
    state_e           state_q, state_d;

    logic enq;
    logic pipe_issue;
    logic head_valid;
    logic head_issue;
    logic pop;
    logic any_valid_d;

    // A same-cycle pop does not free a slot for the incoming result.
    assign md_ready   = (count_q < CntW'(DEPTH));
    // Results for r0 are accepted but dropped.
    assign enq        = md_valid && md_ready && (md_dst != 5'd0);
    assign pipe_issue = wb_we && (wb_dst != 5'd0);
    assign head_valid = (count_q != '0) && vld_q[rd_ptr_q];
    // Any wb_we owns the slot, even a write to r0.
    assign head_issue = !wb_we && head_valid;
    // Squashed heads are discarded without using the port.
    assign pop        = head_issue || ((count_q != '0) && !vld_q[rd_ptr_q]);
    assign any_valid_d = |vld_d;
    assign wb_stall   = (state_q == StForce);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (((rs_addr != 5'd0) && (rs_addr == dst_q[i])) ||
                             ((rt_addr != 5'd0) && (rt_addr == dst_q[i])))) begin
                hazard = 1'b1;
            end
        end
        if (enq && ((rs_addr == md_dst) || (rt_addr == md_dst))) begin
            hazard = 1'b1;
        end
    end

    always_comb begin
        dst_d    = dst_q;
        data_d   = data_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        // A newer pipeline value kills every older buffered write to that register.
        if (pipe_issue) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (dst_q[i] == wb_dst) begin
                    vld_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PtrW'(1);
        end
        // Never collides with the pop slot: enq needs a non-full FIFO, pop a non-empty one.
        if (enq) begin
            vld_d[wr_ptr_q]  = 1'b1;
            dst_d[wr_ptr_q]  = md_dst;
            data_d[wr_ptr_q] = md_data;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        count_d = count_q + CntW'(enq) - CntW'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (head_issue || !any_valid_d) begin
            starve_d = 8'd0;
        end else if (head_valid && wb_we && (starve_q != Limit)) begin
            starve_d = starve_q + 8'd1;
        end
        unique case (state_q)
            StIdle: begin
                if (any_valid_d) begin
                    state_d = StPend;
                end
            end
            StPend: begin
                if (!any_valid_d) begin
                    state_d = StIdle;
                end else if (starve_d == Limit) begin
                    state_d = StForce;
                end
            end
            StForce: begin
                if (!any_valid_d) begin
                    state_d = StIdle;
                end else if (head_issue) begin
                    state_d = StPend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i]  <= 5'd0;
                data_q[i] <= 32'd0;
            end
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= 8'd0;
            state_q  <= StIdle;
        end else begin
            dst_q    <= dst_d;
            data_q   <= data_d;
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
        end
    end

    // rf_dst/rf_data hold their last value while rf_we is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_dst  <= 5'd0;
            rf_data <= 32'd0;
        end else begin
            rf_we <= pipe_issue || head_issue;
            if (pipe_issue) begin
                rf_dst  <= wb_dst;
                rf_data <= wb_data;
            end else if (head_issue) begin
                rf_dst  <= dst_q[rd_ptr_q];
                rf_data <= data_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_dst = '0;
    logic [31:0] wb_data = '0;
    logic        md_valid = 1'b0;
    logic        md_ready;
    logic [4:0]  md_dst = '0;
    logic [31:0] md_data = '0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic        hazard;
    logic        wb_stall;
    logic        rf_we;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data;

    int n_tests = 0;
    int n_fail  = 0;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_dst(md_dst), .md_data(md_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard(hazard), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending muldiv writes as an ordered list.
    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        bit          v;
    } ent_t;

    ent_t        mq[$];
    int          m_cnt;
    bit          m_stall;
    logic        m_we;
    logic [4:0]  m_dst;
    logic [31:0] m_data;

    function automatic bit m_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].v && (((rs_addr != 0) && (rs_addr == mq[i].dst)) ||
                            ((rt_addr != 0) && (rt_addr == mq[i].dst)))) h = 1'b1;
        end
        if (md_valid && m_ready() && (md_dst != 0) &&
            ((rs_addr == md_dst) || (rt_addr == md_dst))) h = 1'b1;
        return h;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cnt = 0; m_stall = 0; m_we = 0; m_dst = '0; m_data = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit acc, pipe, headv, hiss, anyv;
        ent_t e;
        acc   = md_valid && m_ready();
        pipe  = wb_we && (wb_dst != 0);
        headv = (mq.size() > 0) && mq[0].v;
        hiss  = !wb_we && headv;
        m_we  = pipe || hiss;
        if (pipe) begin
            m_dst = wb_dst; m_data = wb_data;
        end else if (hiss) begin
            m_dst = mq[0].dst; m_data = mq[0].data;
        end
        if (hiss) m_cnt = 0;
        else if (headv && wb_we && m_cnt < LIMIT) m_cnt++;
        if ((mq.size() > 0) && (hiss || !mq[0].v)) void'(mq.pop_front());
        if (pipe) foreach (mq[i]) if (mq[i].dst == wb_dst) mq[i].v = 1'b0;
        if (acc && (md_dst != 0)) begin
            e.dst = md_dst; e.data = md_data; e.v = 1'b1;
            mq.push_back(e);
        end
        anyv = 1'b0;
        foreach (mq[i]) if (mq[i].v) anyv = 1'b1;
        if (!anyv) m_cnt = 0;
        m_stall = anyv && (m_stall ? !hiss : (m_cnt == LIMIT));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_dst = '0; wb_data = '0;
        md_valid = 0; md_dst = '0; md_data = '0;
        rs_addr = '0; rt_addr = '0;
    endtask

    task automatic settle();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        model_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %b want 0", rf_we); end
        n_tests++; if (rf_dst !== 5'd0) begin n_fail++; $display("FAIL reset_rf_dst got %0d want 0", rf_dst); end
        n_tests++; if (rf_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_data got %h want 0", rf_data); end
        n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL reset_wb_stall got %b want 0", wb_stall); end
        n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL reset_md_ready got %b want 1", md_ready); end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got %b want 0", hazard); end
        @(posedge clk); #1;
    endtask

    task automatic test_isolated();
        settle();
        md_valid = 1; md_dst = 5'd5; md_data = 32'hDEADBEEF; rs_addr = 5'd5;
        #1;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL iso_hazard_c0 got %b want 1", hazard); end
        tick();
        md_valid = 0; md_dst = '0; md_data = '0;
        #1;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL iso_hazard_c1 got %b want 1", hazard); end
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL iso_no_bypass got %b want 0", rf_we); end
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL iso_write got we=%b dst=%0d data=%h want 1/5/deadbeef", rf_we, rf_dst, rf_data);
        end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL iso_hazard_c2 got %b want 0", hazard); end
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL iso_single got %b want 0", rf_we); end
    endtask

    task automatic test_priority();
        settle();
        md_valid = 1; md_dst = 5'd3; md_data = 32'h33;
        tick();
        md_valid = 0;
        for (int k = 0; k < 3; k++) begin
            wb_we = 1; wb_dst = 5'd7; wb_data = 32'h70 + k;
            tick();
            n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd7 || rf_data !== 32'h70 + k) begin
                n_fail++; $display("FAIL prio_pipe%0d got we=%b dst=%0d data=%h want 1/7/%h", k, rf_we, rf_dst, rf_data, 32'h70 + k);
            end
        end
        wb_we = 0; wb_dst = '0;
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd3 || rf_data !== 32'h33) begin
            n_fail++; $display("FAIL prio_drain got we=%b dst=%0d data=%h want 1/3/33", rf_we, rf_dst, rf_data);
        end
    endtask

    task automatic test_squash();
        int writes9;
        settle();
        md_valid = 1; md_dst = 5'd9; md_data = 32'h11;
        tick();
        md_valid = 0;
        wb_we = 1; wb_dst = 5'd9; wb_data = 32'h22; rs_addr = 5'd9;
        #1;
        n_tests++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL squash_hazard_pre got %b want 1", hazard); end
        tick();
        wb_we = 0; wb_dst = '0; wb_data = '0;
        writes9 = 0;
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd9 || rf_data !== 32'h22) begin
            n_fail++; $display("FAIL squash_pipe got we=%b dst=%0d data=%h want 1/9/22", rf_we, rf_dst, rf_data);
        end
        #1;
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL squash_hazard_post got %b want 0", hazard); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (rf_we === 1'b1) writes9++;
        end
        n_tests++; if (writes9 !== 0) begin n_fail++; $display("FAIL squash_stale got %0d writes want 0", writes9); end
        n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL squash_ready got %b want 1", md_ready); end
    endtask

    task automatic test_starve();
        settle();
        md_valid = 1; md_dst = 5'd4; md_data = 32'h44;
        tick();
        md_valid = 0;
        for (int k = 1; k <= LIMIT + 1; k++) begin
            wb_we = 1; wb_dst = 5'(16 + k); wb_data = 32'(k);
            tick();
            n_tests++; if (wb_stall !== (k >= LIMIT)) begin
                n_fail++; $display("FAIL starve_stall%0d got %b want %b", k, wb_stall, (k >= LIMIT));
            end
        end
        n_tests++; if (rf_dst !== 5'(17 + LIMIT)) begin
            n_fail++; $display("FAIL starve_pipe_wins got %0d want %0d", rf_dst, 17 + LIMIT);
        end
        wb_we = 0; wb_dst = '0;
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd4 || rf_data !== 32'h44) begin
            n_fail++; $display("FAIL starve_issue got we=%b dst=%0d data=%h want 1/4/44", rf_we, rf_dst, rf_data);
        end
        n_tests++; if (wb_stall !== 1'b0) begin n_fail++; $display("FAIL starve_release got %b want 0", wb_stall); end
    endtask

    task automatic test_full_dst0();
        settle();
        wb_we = 1; wb_dst = 5'd2; wb_data = 32'h2;
        md_valid = 1; md_dst = 5'd1; md_data = 32'hA1;
        tick();
        md_dst = 5'd6; md_data = 32'hB6;
        tick();
        md_dst = 5'd8; md_data = 32'hC8; rt_addr = 5'd8;
        #1;
        n_tests++; if (md_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", md_ready); end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL full_hazard got %b want 0", hazard); end
        tick();
        md_valid = 0; rt_addr = '0;
        wb_dst = 5'd0;
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL dst0_pipe got we=%b want 0", rf_we); end
        wb_we = 0;
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd1) begin
            n_fail++; $display("FAIL full_drain0 got we=%b dst=%0d want 1/1", rf_we, rf_dst);
        end
        tick();
        n_tests++; if (rf_we !== 1'b1 || rf_dst !== 5'd6 || rf_data !== 32'hB6) begin
            n_fail++; $display("FAIL full_drain1 got we=%b dst=%0d data=%h want 1/6/b6", rf_we, rf_dst, rf_data);
        end
        tick();
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL full_rejected got we=%b want 0", rf_we); end
        md_valid = 1; md_dst = 5'd0; md_data = 32'hFF;
        tick();
        md_valid = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL md_dst0_%0d got we=%b want 0", k, rf_we); end
        end
    endtask

    task automatic test_reset_mid();
        settle();
        wb_we = 1; wb_dst = 5'd2; wb_data = 32'h2;
        md_valid = 1; md_dst = 5'd11; md_data = 32'hB;
        tick();
        md_dst = 5'd12; md_data = 32'hC;
        tick();
        md_valid = 0; rs_addr = 5'd11;
        #2 rst_n = 0;
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_rf_we got %b want 0", rf_we); end
        n_tests++; if (rf_dst !== 5'd0 || rf_data !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_rf got dst=%0d data=%h want 0/0", rf_dst, rf_data);
        end
        n_tests++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL rstmid_hazard got %b want 0", hazard); end
        n_tests++; if (md_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", md_ready); end
        model_reset();
        wb_we = 0; wb_dst = '0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (rf_we !== 1'b0 || wb_stall !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_after%0d got we=%b stall=%b want 0/0", k, rf_we, wb_stall);
            end
        end
    endtask

    task automatic test_random();
        int pct;
        settle();
        for (int c = 0; c < 600; c++) begin
            pct = ((c / 100) % 2 == 1) ? 90 : 45;
            wb_we    = ($urandom_range(99) < pct);
            if (m_stall && $urandom_range(99) < 70) wb_we = 0;
            wb_dst   = 5'($urandom_range(7));
            wb_data  = $urandom;
            md_valid = ($urandom_range(99) < 45);
            md_dst   = 5'($urandom_range(7));
            md_data  = $urandom;
            rs_addr  = 5'($urandom_range(7));
            rt_addr  = 5'($urandom_range(7));
            #1;
            n_tests++; if (md_ready !== m_ready()) begin
                n_fail++; $display("FAIL rnd_ready c%0d got %b want %b", c, md_ready, m_ready());
            end
            n_tests++; if (hazard !== m_hazard()) begin
                n_fail++; $display("FAIL rnd_hazard c%0d got %b want %b", c, hazard, m_hazard());
            end
            tick();
            n_tests++; if (rf_we !== m_we || rf_dst !== m_dst || rf_data !== m_data) begin
                n_fail++; $display("FAIL rnd_rf c%0d got %b/%0d/%h want %b/%0d/%h",
                                   c, rf_we, rf_dst, rf_data, m_we, m_dst, m_data);
            end
            n_tests++; if (wb_stall !== m_stall) begin
                n_fail++; $display("FAIL rnd_stall c%0d got %b want %b", c, wb_stall, m_stall);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_isolated();
        test_priority();
        test_squash();
        test_starve();
        test_full_dst0();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and scheduler for the single register-file write port fed by the writeback stage. It shares that port between the in-order pipeline writeback and the multi-cycle multiply/divide unit. Muldiv results are held in a small FIFO and drained in cycles the pipeline leaves idle. The block also flags decode-stage hazards against pending results and forces a pipeline bubble when the muldiv queue starves.

## Interface
- DEPTH, 2, muldiv result FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive blocked cycles before a forced bubble; 1..255
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  pipeline writeback valid (from writeback `rwe`)
- wb_dst  in  5  pipeline destination register (writeback `insn_to_d`)
- wb_data  in  32  pipeline write data (writeback `dataout`)
- md_valid  in  1  muldiv result valid
- md_ready  out  1  FIFO can accept a muldiv result
- md_dst  in  5  muldiv destination register
- md_data  in  32  muldiv result
- rs_addr, rt_addr  in  5 each  decode-stage source registers
- hazard  out  1  a source register has a pending muldiv write
- wb_stall  out  1  pipeline must inject a writeback bubble
- rf_we  out  1  register-file write enable
- rf_dst  out  5  register-file write address
- rf_data  out  32  register-file write data

## Operation
- Reset values:
  - rf_we=0, rf_dst=0, rf_data=0, wb_stall=0.
  - FIFO empty; all entry valid bits clear; starve counter=0; FSM=IDLE.
- Accept: a muldiv result is accepted when md_valid && md_ready.
  - md_ready = (count < DEPTH); it is not increased by a same-cycle pop.
  - An accepted entry with md_dst=0 is discarded and never enqueued.
- Port priority: the pipeline always wins.
  - If wb_we=1 and wb_dst≠0, the pipeline write issues.
  - If wb_we=1 and wb_dst=0, nothing issues and the port stays idle that cycle. The FIFO head may not use that slot.
  - Otherwise, a valid FIFO head issues and is popped.
- Squash: when a pipeline write with wb_dst≠0 issues, every buffered entry with a matching dst has its valid bit cleared in the same cycle. A newer pipeline value is therefore never overwritten by an older muldiv result.
- Invalid head: popped in any cycle without using the port, one per cycle. This pop may coincide with a pipeline write.
- Ordering: entries drain in FIFO order. Duplicate dsts are allowed; last write wins.
- hazard (combinational):
  - Set if rs_addr or rt_addr is nonzero and equals the dst of any valid buffered entry.
  - Also set if it equals md_dst while md_valid && md_ready && md_dst≠0.
- FSM:
  - IDLE: no valid entries.
  - PEND: a valid head exists.
    - Starve counter increments each cycle the valid head is blocked by a pipeline write.
    - The counter resets to 0 when the head issues.
    - When the counter reaches STARVE_LIMIT, go to FORCE.
  - FORCE: wb_stall=1.
    - The pipeline must present wb_we=0 next cycle. If it does not, the pipeline still wins and FORCE holds.
    - Exit to PEND or IDLE in the cycle after the head issues; the counter clears.
  - PEND → IDLE when no valid entries remain.

## Timing
- Registered rf_* outputs: an issue decided in cycle N drives rf_* in cycle N+1 for exactly one cycle.
- Pipeline write: wb_we at edge N gives rf_we at N+1.
- Muldiv write:
  - Accepted at edge N, it enters the FIFO at N+1.
  - Earliest issue decision is cycle N+1, so earliest rf_we is N+2. There is no bypass.
- md_ready, hazard: combinational from registered state plus the current md_valid/md_dst.
- wb_stall: registered. It asserts the cycle after the counter hits STARVE_LIMIT, and deasserts the cycle after the head issues.
- Full FIFO: md_ready=0 even if a pop occurs in the same cycle.
- Reset mid-operation: asynchronous.
  - Buffered entries are lost.
  - rf_we drops immediately.
  - No write completes after rst_n falls.

## Test plan
- Isolated muldiv:
  - Stimulus: idle pipeline; md_valid with dst=5, data=0xDEADBEEF at cycle 0.
  - Required: rf_we=1, rf_dst=5, rf_data=0xDEADBEEF at cycle 2; hazard=1 for rs_addr=5 during cycles 0–1.
- Priority:
  - Stimulus: FIFO holds dst=3; wb_we=1, wb_dst=7 for 3 cycles.
  - Required: rf_dst=7 for those 3 cycles, then rf_dst=3 the following cycle.
- Squash:
  - Stimulus: FIFO holds dst=9, data=0x11; pipeline writes dst=9, data=0x22.
  - Required: only one rf write to register 9 (0x22); the entry is popped invalid; hazard for 9 clears.
- Starvation (STARVE_LIMIT=8):
  - Stimulus: FIFO nonempty; wb_we=1 continuously.
  - Required: wb_stall=1 after 8 blocked cycles. Bench drops wb_we; the head issues; wb_stall=0 one cycle later.
- Full, dst 0, and reset:
  - DEPTH=2 filled: md_ready=0.
  - md_dst=0 accepted: never writes.
  - Pipeline wb_dst=0: rf_we=0 and the head is not issued that cycle.
  - rst_n pulsed low with 2 entries queued: all outputs at reset values, FIFO empty, no later writes.
